// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store unit; one memory op in flight, byte-lane steering for stores,
//           sign/zero extension for loads, misalignment/illegal-width fault detection.
// Latency : load accept T -> request T+1 -> response T+2 -> writeback T+3; store done at T+2.
// Backpressure: ex_ready is high only in IDLE; the memory request is held stable until mem_req_ready.
// Ports   : clock/reset_n; ex_* op from execute stage (valid/ready); mem_req_* request channel
//           (valid/ready); mem_rsp_* read response; wb_* load writeback pulse; lsu_done and
//           misaligned completion/fault pulses.
module load_store_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_done,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [4:0]  op_rd;
  logic        accept;
  logic        illegal;
  logic [31:0] rsp_shifted;
  logic [31:0] load_data;

  // Width/alignment legality of the op currently presented; BU/HU exist only as loads.
  always_comb begin
    illegal = 1'b0;
    case (ex_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = ex_addr[0];
      3'b010:  illegal = |ex_addr[1:0];
      3'b100:  illegal = ex_is_store;
      3'b101:  illegal = ex_is_store | ex_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  assign accept = ex_valid && ex_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ex_ready      = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        // Faulting ops complete without leaving IDLE.
        if (ex_valid && !illegal) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = op_store ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are driven from captured state only, so they cannot move while stalled;
  // they read as zero whenever no request is outstanding.
  always_comb begin
    mem_req_addr  = 32'h0;
    mem_req_we    = 1'b0;
    mem_req_be    = 4'h0;
    mem_req_wdata = 32'h0;
    if (mem_req_valid) begin
      mem_req_addr = {op_addr[31:2], 2'b00};
      mem_req_we   = op_store;
      mem_req_be   = 4'hF;
      if (op_store) begin
        case (op_funct3[1:0])
          2'b00: begin
            mem_req_be    = 4'b0001 << op_addr[1:0];
            mem_req_wdata = {4{op_wdata[7:0]}};
          end
          2'b01: begin
            mem_req_be    = op_addr[1] ? 4'b1100 : 4'b0011;
            mem_req_wdata = {2{op_wdata[15:0]}};
          end
          default: begin
            mem_req_be    = 4'hF;
            mem_req_wdata = op_wdata;
          end
        endcase
      end
    end
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign rsp_shifted = mem_rsp_rdata >> {op_addr[1:0], 3'b000};

  always_comb begin
    load_data = rsp_shifted;
    case (op_funct3)
      3'b000:  load_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_data = {24'h0, rsp_shifted[7:0]};
      3'b101:  load_data = {16'h0, rsp_shifted[15:0]};
      default: load_data = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_store   <= 1'b0;
      op_funct3  <= 3'b000;
      op_addr    <= 32'h0;
      op_wdata   <= 32'h0;
      op_rd      <= 5'd0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0;
      lsu_done   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      lsu_done   <= 1'b0;
      misaligned <= 1'b0;
      if (accept) begin
        op_store  <= ex_is_store;
        op_funct3 <= ex_funct3;
        op_addr   <= ex_addr;
        op_wdata  <= ex_wdata;
        op_rd     <= ex_rd;
        if (illegal) begin
          misaligned <= 1'b1;
          lsu_done   <= 1'b1;
        end
      end
      if (state == REQ && mem_req_ready && op_store) lsu_done <= 1'b1;
      if (state == WAIT && mem_rsp_valid) begin
        wb_valid <= 1'b1;
        lsu_done <= 1'b1;
        wb_rd    <= op_rd;
        wb_data  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : directed table-driven bench for load_store_unit plus stall and reset-in-WAIT sequences.
// Latency : checks exact cycle placement of request, response and completion pulses.
// Backpressure: exercises mem_req_ready held low for several cycles.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_done;
  logic        misaligned;

  load_store_unit dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .lsu_done(lsu_done), .misaligned(misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] wbdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Applies one op with the memory always ready and a minimum-latency response.
  task automatic do_op(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clock);
    check({p, ".ex_ready"}, 32'(ex_ready), 32'd1);
    ex_valid      = 1'b1;
    ex_is_store   = v.st;
    ex_funct3     = v.f3;
    ex_addr       = v.addr;
    ex_wdata      = v.wdata;
    ex_rd         = v.rd;
    mem_req_ready = 1'b1;
    @(negedge clock);
    ex_valid = 1'b0;
    if (v.bad) begin
      check({p, ".misaligned"}, 32'(misaligned), 32'd1);
      check({p, ".done_fault"}, 32'(lsu_done), 32'd1);
      check({p, ".no_req"}, 32'(mem_req_valid), 32'd0);
      check({p, ".ready_fault"}, 32'(ex_ready), 32'd1);
      @(negedge clock);
      check({p, ".misaligned_end"}, 32'(misaligned), 32'd0);
      check({p, ".done_end"}, 32'(lsu_done), 32'd0);
      check({p, ".no_req_later"}, 32'(mem_req_valid), 32'd0);
    end else begin
      check({p, ".req_valid"}, 32'(mem_req_valid), 32'd1);
      check({p, ".req_addr"}, mem_req_addr, {v.addr[31:2], 2'b00});
      check({p, ".req_we"}, 32'(mem_req_we), 32'(v.st));
      check({p, ".req_be"}, 32'(mem_req_be), 32'(v.be));
      if (v.st) check({p, ".req_wdata"}, mem_req_wdata, v.mwdata);
      check({p, ".busy"}, 32'(ex_ready), 32'd0);
      check({p, ".early_done"}, 32'(lsu_done), 32'd0);
      if (v.st) begin
        @(negedge clock);
        check({p, ".st_done"}, 32'(lsu_done), 32'd1);
        check({p, ".st_no_wb"}, 32'(wb_valid), 32'd0);
        check({p, ".st_no_fault"}, 32'(misaligned), 32'd0);
        check({p, ".st_req_drop"}, 32'(mem_req_valid), 32'd0);
        check({p, ".st_ready"}, 32'(ex_ready), 32'd1);
      end else begin
        @(negedge clock);
        check({p, ".ld_req_drop"}, 32'(mem_req_valid), 32'd0);
        check({p, ".ld_wait_busy"}, 32'(ex_ready), 32'd0);
        check({p, ".ld_no_early_wb"}, 32'(wb_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = v.rdata;
        @(negedge clock);
        mem_rsp_valid = 1'b0;
        check({p, ".wb_valid"}, 32'(wb_valid), 32'd1);
        check({p, ".ld_done"}, 32'(lsu_done), 32'd1);
        check({p, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
        check({p, ".wb_data"}, wb_data, v.wbdata);
        check({p, ".ld_no_fault"}, 32'(misaligned), 32'd0);
        check({p, ".ld_ready"}, 32'(ex_ready), 32'd1);
        @(negedge clock);
        check({p, ".wb_pulse_end"}, 32'(wb_valid), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    //            st    f3      addr          wdata         rd     rdata         bad   be      mwdata        wbdata
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        5'd1,  32'h80FF_FF7F, 1'b0, 4'hF,   32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b100, 32'h0000_1003, 32'h0,        5'd2,  32'h80FF_FF7F, 1'b0, 4'hF,   32'h0,        32'h0000_0080};
    vecs[2]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0,        5'd3,  32'h80FF_FF7F, 1'b0, 4'hF,   32'h0,        32'hFFFF_80FF};
    vecs[3]  = '{1'b0, 3'b101, 32'h0000_1000, 32'h0,        5'd4,  32'h80FF_FF7F, 1'b0, 4'hF,   32'h0,        32'h0000_FF7F};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_1000, 32'h0,        5'd5,  32'h1234_7FFF, 1'b0, 4'hF,   32'h0,        32'h0000_7FFF};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_1004, 32'h0,        5'd31, 32'hDEAD_BEEF, 1'b0, 4'hF,   32'h0,        32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 3'b000, 32'h0000_1001, 32'h0,        5'd0,  32'h1122_7A33, 1'b0, 4'hF,   32'h0,        32'h0000_007A};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[8]  = '{1'b1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 5'd0, 32'h0,         1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{1'b1, 3'b001, 32'h0000_2000, 32'hCAFE_1234, 5'd0, 32'h0,         1'b0, 4'b0011, 32'h1234_1234, 32'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_2008, 32'hCAFE_F00D, 5'd0, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1'b1, 3'b000, 32'h0000_2003, 32'h0000_007E, 5'd0, 32'h0,         1'b0, 4'b1000, 32'h7E7E_7E7E, 32'h0};
    vecs[12] = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,        5'd6,  32'h0,         1'b1, 4'h0,   32'h0,        32'h0};
    vecs[13] = '{1'b0, 3'b001, 32'h0000_3003, 32'h0,        5'd6,  32'h0,         1'b1, 4'h0,   32'h0,        32'h0};
    vecs[14] = '{1'b1, 3'b010, 32'h0000_3002, 32'h1,        5'd0,  32'h0,         1'b1, 4'h0,   32'h0,        32'h0};
    vecs[15] = '{1'b0, 3'b011, 32'h0000_3000, 32'h0,        5'd6,  32'h0,         1'b1, 4'h0,   32'h0,        32'h0};
    vecs[16] = '{1'b1, 3'b100, 32'h0000_3000, 32'h1,        5'd0,  32'h0,         1'b1, 4'h0,   32'h0,        32'h0};
    vecs[17] = '{1'b0, 3'b101, 32'h0000_3001, 32'h0,        5'd6,  32'h0,         1'b1, 4'h0,   32'h0,        32'h0};

    reset_n       = 1'b0;
    ex_valid      = 1'b0;
    ex_is_store   = 1'b0;
    ex_funct3     = 3'b000;
    ex_addr       = 32'h0;
    ex_wdata      = 32'h0;
    ex_rd         = 5'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;

    // Reset state
    #2;
    check("rst.ex_ready", 32'(ex_ready), 32'd1);
    check("rst.req_valid", 32'(mem_req_valid), 32'd0);
    check("rst.req_addr", mem_req_addr, 32'h0);
    check("rst.req_be", 32'(mem_req_be), 32'd0);
    check("rst.req_we", 32'(mem_req_we), 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_data", wb_data, 32'h0);
    check("rst.done", 32'(lsu_done), 32'd0);
    check("rst.misaligned", 32'(misaligned), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) do_op(vecs[i], i);

    // SW held off by mem_req_ready for three cycles; junk on ex_* must not disturb it.
    @(negedge clock);
    mem_req_ready = 1'b0;
    ex_valid      = 1'b1;
    ex_is_store   = 1'b1;
    ex_funct3     = 3'b010;
    ex_addr       = 32'h0000_5004;
    ex_wdata      = 32'h0BAD_CAFE;
    ex_rd         = 5'd0;
    @(negedge clock);
    ex_addr  = 32'h0000_7771;
    ex_wdata = 32'h5555_5555;
    ex_funct3 = 3'b000;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall%0d.req_valid", k), 32'(mem_req_valid), 32'd1);
      check($sformatf("stall%0d.req_addr", k), mem_req_addr, 32'h0000_5004);
      check($sformatf("stall%0d.req_we", k), 32'(mem_req_we), 32'd1);
      check($sformatf("stall%0d.req_be", k), 32'(mem_req_be), 32'hF);
      check($sformatf("stall%0d.req_wdata", k), mem_req_wdata, 32'h0BAD_CAFE);
      check($sformatf("stall%0d.ex_ready", k), 32'(ex_ready), 32'd0);
      check($sformatf("stall%0d.done", k), 32'(lsu_done), 32'd0);
      if (k == 3) begin
        mem_req_ready = 1'b1;
        ex_valid      = 1'b0;
      end
      @(negedge clock);
    end
    check("stall.done", 32'(lsu_done), 32'd1);
    check("stall.no_wb", 32'(wb_valid), 32'd0);
    check("stall.req_drop", 32'(mem_req_valid), 32'd0);
    check("stall.ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clock);
    check("stall.done_end", 32'(lsu_done), 32'd0);

    // LHU in WAIT killed by reset, followed by a stale response.
    ex_valid    = 1'b1;
    ex_is_store = 1'b0;
    ex_funct3   = 3'b101;
    ex_addr     = 32'h0000_4002;
    ex_rd       = 5'd7;
    @(negedge clock);
    ex_valid = 1'b0;
    check("rstw.req_valid", 32'(mem_req_valid), 32'd1);
    check("rstw.req_addr", mem_req_addr, 32'h0000_4000);
    @(negedge clock);
    check("rstw.in_wait", 32'(ex_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rstw.async_ready", 32'(ex_ready), 32'd1);
    check("rstw.async_req", 32'(mem_req_valid), 32'd0);
    @(negedge clock);
    reset_n       = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("rstw%0d.no_wb", k), 32'(wb_valid), 32'd0);
      check($sformatf("rstw%0d.no_done", k), 32'(lsu_done), 32'd0);
      check($sformatf("rstw%0d.ex_ready", k), 32'(ex_ready), 32'd1);
      check($sformatf("rstw%0d.no_req", k), 32'(mem_req_valid), 32'd0);
    end
    mem_rsp_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
